// File: rtl/led_matrix_row_driver.sv
// ---------------------------------------------------------------------------
// led_matrix_row_driver
//
// Drives one row pair (top half / bottom half) of a HUB75-style RGB LED
// matrix. A row is accepted from the row buffers and shifted out MSB
// column first on a divided bit clock. An optional blanking interval
// follows. The row is then latched at its address and the display is
// re-enabled. The previously latched row stays lit (oe_n_out low) while
// the next row is shifted in.
//
// Build option: define LED_DRIVER_BLANK_EN to insert BLANK_CYCLES of
// blanking before each latch. When it is undefined, blanking is skipped,
// the address updates on latch entry and oe_n_out is high only while
// latching.
//
// Ports:
//   clk_in          system clock
//   n_reset_in      asynchronous active-low reset
//   enable_in       row data valid (sampled only in IDLE)
//   ready_out       row can be accepted
//   frame_sync_in   restart row counter at 0 (sampled only in IDLE)
//   col_top_in      top-half row, [colour][column]
//   col_bot_in      bottom-half row, [colour][column]
//   rgb_top_out     top-half RGB serial data
//   rgb_bot_out     bottom-half RGB serial data
//   bit_clk_out     shift clock to the panel
//   latch_out       row latch strobe
//   oe_n_out        active-low output enable
//   addr_out        row address
//   row_done_out    one-cycle pulse per completed row
//   frame_done_out  one-cycle pulse when the last row of a frame completes
// ---------------------------------------------------------------------------
module led_matrix_row_driver #(
    parameter int WRITE_FREQ   = 1_000_000,
    parameter int SYS_CLK_FREQ = 100_000_000,
    parameter int NUM_COLS     = 64,
    parameter int ADDR_W       = 5,
    parameter int LATCH_CYCLES = 4,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                         clk_in,
    input  logic                         n_reset_in,
    input  logic                         enable_in,
    output logic                         ready_out,
    input  logic                         frame_sync_in,
    input  logic [2:0][NUM_COLS-1:0]     col_top_in,
    input  logic [2:0][NUM_COLS-1:0]     col_bot_in,
    output logic [2:0]                   rgb_top_out,
    output logic [2:0]                   rgb_bot_out,
    output logic                         bit_clk_out,
    output logic                         latch_out,
    output logic                         oe_n_out,
    output logic [ADDR_W-1:0]            addr_out,
    output logic                         row_done_out,
    output logic                         frame_done_out
);

    localparam int HALF_RAW = SYS_CLK_FREQ / (2 * WRITE_FREQ);
    localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int MAX_A    = (HALF > LATCH_CYCLES) ? HALF : LATCH_CYCLES;
    localparam int MAX_CNT  = (MAX_A > BLANK_CYCLES) ? MAX_A : BLANK_CYCLES;
    localparam int CNT_W    = $clog2(MAX_CNT + 1);
    localparam int COL_W    = $clog2(NUM_COLS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        BLANK = 3'd2,
        LATCH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                      state_r;
    logic [CNT_W-1:0]            cnt_r;
    logic [COL_W-1:0]            col_cnt_r;
    logic [ADDR_W-1:0]           row_cnt_r;
    // Column NUM_COLS-1 goes straight to the outputs on acceptance, so the
    // buffers only hold the remaining columns, MSB next to be shown.
    logic [2:0][NUM_COLS-2:0]    top_buf_r;
    logic [2:0][NUM_COLS-2:0]    bot_buf_r;
    logic                        ready_r;
    logic [2:0]                  rgb_top_r;
    logic [2:0]                  rgb_bot_r;
    logic                        bit_clk_r;
    logic                        latch_r;
    logic                        oe_n_r;
    logic [ADDR_W-1:0]           addr_r;
    logic                        row_done_r;
    logic                        frame_done_r;

    // Row sequencer: accept, shift, optional blank, latch, done.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            col_cnt_r    <= '0;
            row_cnt_r    <= '0;
            top_buf_r    <= '0;
            bot_buf_r    <= '0;
            ready_r      <= 1'b1;
            rgb_top_r    <= 3'b000;
            rgb_bot_r    <= 3'b000;
            bit_clk_r    <= 1'b0;
            latch_r      <= 1'b0;
            oe_n_r       <= 1'b1;
            addr_r       <= '0;
            row_done_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            row_done_r   <= 1'b0;
            frame_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (frame_sync_in) begin
                        row_cnt_r <= '0;
                    end
                    if (enable_in) begin
                        for (int c = 0; c < 3; c++) begin
                            top_buf_r[c] <= col_top_in[c][NUM_COLS-2:0];
                            bot_buf_r[c] <= col_bot_in[c][NUM_COLS-2:0];
                            rgb_top_r[c] <= col_top_in[c][NUM_COLS-1];
                            rgb_bot_r[c] <= col_bot_in[c][NUM_COLS-1];
                        end
                        ready_r   <= 1'b0;
                        cnt_r     <= '0;
                        col_cnt_r <= '0;
                        bit_clk_r <= 1'b0;
                        state_r   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_r == CNT_W'(HALF - 1)) begin
                        cnt_r     <= '0;
                        bit_clk_r <= ~bit_clk_r;
                        // Data advances on the falling bit clock edge.
                        if (bit_clk_r) begin
                            if (col_cnt_r == COL_W'(NUM_COLS - 1)) begin
                                rgb_top_r <= 3'b000;
                                rgb_bot_r <= 3'b000;
                                oe_n_r    <= 1'b1;
                                addr_r    <= row_cnt_r;
`ifdef LED_DRIVER_BLANK_EN
                                state_r   <= BLANK;
`else
                                latch_r   <= 1'b1;
                                state_r   <= LATCH;
`endif
                            end else begin
                                col_cnt_r <= col_cnt_r + 1'b1;
                                for (int c = 0; c < 3; c++) begin
                                    rgb_top_r[c] <= top_buf_r[c][NUM_COLS-2];
                                    rgb_bot_r[c] <= bot_buf_r[c][NUM_COLS-2];
                                    top_buf_r[c] <= top_buf_r[c] << 1;
                                    bot_buf_r[c] <= bot_buf_r[c] << 1;
                                end
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt_r == CNT_W'(BLANK_CYCLES - 1)) begin
                        cnt_r   <= '0;
                        latch_r <= 1'b1;
                        state_r <= LATCH;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                LATCH: begin
                    if (cnt_r == CNT_W'(LATCH_CYCLES - 1)) begin
                        cnt_r        <= '0;
                        latch_r      <= 1'b0;
                        oe_n_r       <= 1'b0;
                        row_done_r   <= 1'b1;
                        frame_done_r <= (row_cnt_r == {ADDR_W{1'b1}});
                        state_r      <= DONE;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                DONE: begin
                    row_cnt_r <= row_cnt_r + 1'b1;
                    ready_r   <= 1'b1;
                    state_r   <= IDLE;
                end
                default: begin
                    // Unreachable encodings: recover to a safe, blanked IDLE.
                    state_r   <= IDLE;
                    ready_r   <= 1'b1;
                    cnt_r     <= '0;
                    rgb_top_r <= 3'b000;
                    rgb_bot_r <= 3'b000;
                    bit_clk_r <= 1'b0;
                    latch_r   <= 1'b0;
                    oe_n_r    <= 1'b1;
                end
            endcase
        end
    end

    assign ready_out      = ready_r;
    assign rgb_top_out    = rgb_top_r;
    assign rgb_bot_out    = rgb_bot_r;
    assign bit_clk_out    = bit_clk_r;
    assign latch_out      = latch_r;
    assign oe_n_out       = oe_n_r;
    assign addr_out       = addr_r;
    assign row_done_out   = row_done_r;
    assign frame_done_out = frame_done_r;

endmodule

// File: tb/tb_led_matrix_row_driver.sv
// ---------------------------------------------------------------------------
// tb_led_matrix_row_driver
//
// Scoreboard bench for led_matrix_row_driver with NUM_COLS=4, ADDR_W=2,
// HALF=4, LATCH_CYCLES=2, BLANK_CYCLES=3. The stimulus thread pushes the
// expected column data and the expected row completion into queues. A
// monitor pops them on each bit clock rise and on each row_done pulse.
// ---------------------------------------------------------------------------
module tb_led_matrix_row_driver;

    localparam int NC = 4;
    localparam int AW = 2;
`ifdef LED_DRIVER_BLANK_EN
    localparam int EXP_PERIOD = 39;
    localparam int EXP_OE     = 5;
`else
    localparam int EXP_PERIOD = 36;
    localparam int EXP_OE     = 2;
`endif
    localparam int EXP_LATCH   = 2;
    localparam int EXP_SPACING = 8;

    logic                 clk = 1'b0;
    logic                 n_reset = 1'b0;
    logic                 enable = 1'b0;
    logic                 frame_sync = 1'b0;
    logic [2:0][NC-1:0]   col_top = '0;
    logic [2:0][NC-1:0]   col_bot = '0;
    logic                 ready_out;
    logic [2:0]           rgb_top_out;
    logic [2:0]           rgb_bot_out;
    logic                 bit_clk_out;
    logic                 latch_out;
    logic                 oe_n_out;
    logic [AW-1:0]        addr_out;
    logic                 row_done_out;
    logic                 frame_done_out;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [5:0] rgb;
        logic       first;
    } rgb_exp_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          frame;
    } row_exp_t;

    rgb_exp_t rgb_q[$];
    row_exp_t row_q[$];

    led_matrix_row_driver #(
        .WRITE_FREQ   (1),
        .SYS_CLK_FREQ (8),
        .NUM_COLS     (NC),
        .ADDR_W       (AW),
        .LATCH_CYCLES (2),
        .BLANK_CYCLES (3)
    ) dut (
        .clk_in         (clk),
        .n_reset_in     (n_reset),
        .enable_in      (enable),
        .ready_out      (ready_out),
        .frame_sync_in  (frame_sync),
        .col_top_in     (col_top),
        .col_bot_in     (col_bot),
        .rgb_top_out    (rgb_top_out),
        .rgb_bot_out    (rgb_bot_out),
        .bit_clk_out    (bit_clk_out),
        .latch_out      (latch_out),
        .oe_n_out       (oe_n_out),
        .addr_out       (addr_out),
        .row_done_out   (row_done_out),
        .frame_done_out (frame_done_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},   32'(ready_out), 32'd1);
        chk({tag, "_rgb"},     32'({rgb_top_out, rgb_bot_out}), 32'd0);
        chk({tag, "_bitclk"},  32'(bit_clk_out), 32'd0);
        chk({tag, "_latch"},   32'(latch_out), 32'd0);
        chk({tag, "_oe_n"},    32'(oe_n_out), 32'd1);
        chk({tag, "_addr"},    32'(addr_out), 32'd0);
        chk({tag, "_pulses"},  32'({row_done_out, frame_done_out}), 32'd0);
    endtask

    // Expected column data, column NC-1 first, packed {top rgb, bottom rgb}.
    task automatic push_rgb(input logic [2:0][NC-1:0] top, input logic [2:0][NC-1:0] bot,
                            input int ncols);
        rgb_exp_t e;
        for (int k = 0; k < ncols; k++) begin
            for (int c = 0; c < 3; c++) begin
                e.rgb[3+c] = top[c][NC-1-k];
                e.rgb[c]   = bot[c][NC-1-k];
            end
            e.first = (k == 0);
            rgb_q.push_back(e);
        end
    endtask

    // Issue one row and check its period and oe/latch pulse widths.
    task automatic send_row(input logic [2:0][NC-1:0] top, input logic [2:0][NC-1:0] bot,
                            input logic [AW-1:0] exp_addr, input logic exp_frame,
                            input logic fsync, input logic hold_en, input logic check_oe);
        int cyc;
        int oe_cnt;
        int lat_cnt;
        row_exp_t r;
        push_rgb(top, bot, NC);
        r.addr  = exp_addr;
        r.frame = exp_frame;
        row_q.push_back(r);
        @(negedge clk);
        col_top    = top;
        col_bot    = bot;
        enable     = 1'b1;
        frame_sync = fsync;
        @(posedge clk);
        #1;
        if (!hold_en) enable = 1'b0;
        frame_sync = 1'b0;
        cyc = 1;
        oe_cnt = 0;
        lat_cnt = 0;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ready_out) break;
            if (oe_n_out) oe_cnt++;
            if (latch_out) lat_cnt++;
        end
        enable = 1'b0;
        chk("row_period", 32'(cyc), 32'(EXP_PERIOD));
        chk("latch_width", 32'(lat_cnt), 32'(EXP_LATCH));
        if (check_oe) chk("oe_n_high", 32'(oe_cnt), 32'(EXP_OE));
        if (hold_en) begin
            repeat (3) @(posedge clk);
            #1;
            chk("single_accept", 32'(ready_out), 32'd1);
        end
    endtask

    // Monitor: compare column data at bit clock rises and row results at row_done.
    initial begin
        logic prev_bclk;
        int   mon_cyc;
        int   last_rise;
        rgb_exp_t e;
        row_exp_t r;
        prev_bclk = 1'b0;
        mon_cyc = 0;
        last_rise = 0;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (bit_clk_out && !prev_bclk) begin
                if (rgb_q.size() == 0) begin
                    chk("rgb_unexpected_rise", 32'd1, 32'd0);
                end else begin
                    e = rgb_q.pop_front();
                    chk("rgb_col", 32'({rgb_top_out, rgb_bot_out}), 32'(e.rgb));
                    if (!e.first) chk("rise_spacing", 32'(mon_cyc - last_rise), 32'(EXP_SPACING));
                end
                last_rise = mon_cyc;
            end
            prev_bclk = bit_clk_out;
            if (row_done_out) begin
                if (row_q.size() == 0) begin
                    chk("row_done_unexpected", 32'd1, 32'd0);
                end else begin
                    r = row_q.pop_front();
                    chk("row_addr", 32'(addr_out), 32'(r.addr));
                    chk("frame_done", 32'(frame_done_out), 32'(r.frame));
                end
            end else if (frame_done_out) begin
                chk("frame_done_without_row", 32'd1, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0][NC-1:0] pat_a;
        logic [2:0][NC-1:0] pat_b_t;
        logic [2:0][NC-1:0] pat_b_b;
        logic [2:0][NC-1:0] pat_c_t;
        logic [2:0][NC-1:0] pat_c_b;
        logic [2:0][NC-1:0] ones;
        logic [2:0][NC-1:0] zeros;
        logic [2:0][NC-1:0] pat_r_t;
        logic [2:0][NC-1:0] pat_r_b;
        pat_a   = {4'b1010, 4'b1010, 4'b1010};
        pat_b_t = {4'b1100, 4'b0011, 4'b0101};
        pat_b_b = {4'b1001, 4'b0110, 4'b1111};
        pat_c_t = {4'b0001, 4'b0010, 4'b0100};
        pat_c_b = {4'b1000, 4'b0000, 4'b1110};
        ones    = {4'b1111, 4'b1111, 4'b1111};
        zeros   = {4'b0000, 4'b0000, 4'b0000};
        pat_r_t = {4'b1000, 4'b1000, 4'b1000};
        pat_r_b = {4'b0111, 4'b0111, 4'b0111};

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 32'(ready_out), 32'd1);

        // Frame of four rows; the first row is the 1010 pattern.
        send_row(pat_a,   pat_a,   2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_row(pat_b_t, pat_b_b, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_row(pat_c_t, pat_c_b, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        send_row(ones,    zeros,   2'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        // Wrapped row, enable held high through the shift.
        send_row(zeros,   ones,    2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_row(pat_b_b, pat_c_t, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        // frame_sync coincident with enable: address 0, no frame_done.
        send_row(pat_c_b, pat_b_t, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        send_row(pat_a,   ones,    2'd1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset during the second bit: only the first rise is seen.
        push_rgb(ones, pat_a, 1);
        @(negedge clk);
        col_top = ones;
        col_bot = pat_a;
        enable  = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        n_reset = 1'b0;
        #1;
        check_reset_outputs("midrow_reset");
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        send_row(pat_r_t, pat_r_b, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        chk("rgb_queue_empty", 32'(rgb_q.size()), 32'd0);
        chk("row_queue_empty", 32'(row_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
